sharp_overlay: RTL and testbench
================================

# sharp_overlay

Sprite-placement stage that sits directly upstream of `sharp_rom` in the display pipeline. It holds a small table of on-screen sharp-symbol positions and scans each incoming pixel coordinate against it. On a hit it issues the glyph-local ROM address to `sharp_rom`, then realigns the returned `pixel_out` with a delayed hit flag. The result is a per-pixel overlay bit for the colour mixer.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of independently placed sharp glyphs.
- `X_W`, 10: pixel x-coordinate width.
- `Y_W`, 10: pixel y-coordinate width.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  write strobe into the shadow slot table.
- `wr_slot`  input  $clog2(NUM_SLOTS)  slot index to write.
- `wr_x`  input  X_W  glyph top-left x.
- `wr_y`  input  Y_W  glyph top-left y.
- `wr_vis`  input  1  slot visible flag.
- `frame_start`  input  1  one-cycle pulse at the start of vertical blank; commits the shadow table to the active table.
- `pix_valid`  input  1  active-video qualifier for `pix_x`/`pix_y`.
- `pix_x`  input  X_W  current pixel x.
- `pix_y`  input  Y_W  current pixel y.
- `rom_addr`  output  8  address to `sharp_rom`, registered.
- `rom_pixel`  input  1  `sharp_rom` `pixel_out`; valid 1 cycle after `rom_addr`.
- `overlay_on`  output  1  draw sharp-symbol colour at this pixel.
- `overlay_valid`  output  1  `pix_valid` delayed to align with `overlay_on`.

## Operation
- Glyph geometry is fixed at 10 wide by 16 tall. ROM index = row*10 + col, range 0..159.
- Shadow table: per slot {x, y, vis}. `wr_en` updates the addressed slot on the clock edge.
- Active table: copied in full from the shadow table on `frame_start`. Scan comparisons use the active table only, so there is no tearing mid-frame.
- Simultaneous `wr_en` and `frame_start`: the write lands in the shadow table and is included in the same commit. The active table therefore equals the post-write shadow.
- Hit test per slot: vis && pix_valid && pix_x >= x && pix_x < x+10 && pix_y >= y && pix_y < y+16.
  - Compute the sums at X_W+1 and Y_W+1 bits so glyphs near the coordinate maximum do not wrap.
- Priority: on overlapping hits, the lowest slot index wins.
- Local offsets: col = pix_x - x (4 bits), row = pix_y - y (4 bits). The address is formed as (row<<3) + (row<<1) + col. No multiplier.
- No hit: `rom_addr` is driven to 0 and the delayed hit flag is 0. `overlay_on` is then forced to 0 regardless of `rom_pixel`.
- `wr_slot` >= NUM_SLOTS (only possible when NUM_SLOTS is not a power of 2): the write is ignored.

## Timing
- Coordinates presented in cycle N:
  - `rom_addr` updates at edge N+1.
  - `rom_pixel` is valid during cycle N+1 to N+2, coming from `sharp_rom`'s registered read.
  - `overlay_on` and `overlay_valid` update at edge N+2, so they are registered outputs.
- Total latency is 2 cycles. Downstream must delay sync signals by 2.
- Pipeline registers: hit_d1 and valid_d1 (stage 1, alongside `rom_addr`); `overlay_on` = rom_pixel & hit_d1 and `overlay_valid` = valid_d1 (stage 2).
- Fully pipelined: one pixel per clock, no stalls, no backpressure.
- `frame_start` commit takes effect on the next cycle's comparisons.
- Reset values:
  - Shadow and active tables: all vis=0, x=0, y=0.
  - `rom_addr`=0, `overlay_on`=0, `overlay_valid`=0, and all pipeline flags 0.
- Reset mid-frame: outputs are 0 on the edge after reset is asserted. In-flight pixels are discarded and nothing is drawn until a commit after reset deasserts.

## Structure
- Shared display package holds:
  - `GLYPH_W`=10, `GLYPH_H`=16, `GLYPH_ADDR_W`=8.
  - A `glyph_slot_t` struct {x, y, vis}.
- The same package constants are used by `sharp_rom` and any future accidental ROMs.
- One sub-module: `glyph_hit` is a combinational per-slot comparator plus offset generator, instantiated NUM_SLOTS times. The priority select and pipeline live in the top.

## Test plan
- Reset, then scan a full line with pix_valid=1 → `overlay_on`=0 and `rom_addr`=0 throughout.
- Slot0 written with x=100, y=50, vis=1, then `frame_start`; drive pix=(103,54) → `rom_addr`=43 at N+1 and `overlay_on`=1 at N+2. Pix (99,54) and (110,54) → no hit.
- Slot0 at (100,50) and slot1 at (105,50); drive pix=(106,50) → address uses slot0, col=6 → `rom_addr`=6.
- Write slot0 with x=200 without `frame_start` → scans still use x=100. Assert `wr_en` in the same cycle as `frame_start` → the new value is active from the next cycle.
- Slot at x=1020, y=1010 with X_W=Y_W=10; pix=(1023,1013) → hit with `rom_addr`=33. Pix=(0,1013) → no hit.
- Assert reset while `overlay_on`=1 → outputs 0 on the next edge; after release, no hits until a new commit.

Source files
------------

// File: rtl/sharp_overlay_pkg.sv
// Shared display constants and the glyph placement record used by the
// sharp-symbol overlay and its glyph ROM.
package sharp_overlay_pkg;

   localparam int GLYPH_W      = 10;
   localparam int GLYPH_H      = 16;
   localparam int GLYPH_ADDR_W = 8;
   localparam int COORD_W      = 10;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               vis;
   } glyph_slot_t;

endpackage

// File: rtl/glyph_hit.sv
// Combinational hit test of one pixel against one placed glyph, plus the
// glyph-local ROM address (row*10 + col) for that pixel.
module glyph_hit
   import sharp_overlay_pkg::*;
#(
   parameter int X_W = 10,
   parameter int Y_W = 10
) (
   input  logic [X_W-1:0]          slot_x,
   input  logic [Y_W-1:0]          slot_y,
   input  logic                    slot_vis,
   input  logic                    pix_valid,
   input  logic [X_W-1:0]          pix_x,
   input  logic [Y_W-1:0]          pix_y,
   output logic                    hit,
   output logic [GLYPH_ADDR_W-1:0] addr
);

   logic [X_W:0] x_end;
   logic [Y_W:0] y_end;
   logic [3:0]   col;
   logic [3:0]   row;

   // One extra bit so glyphs placed near the coordinate maximum do not wrap.
   assign x_end = {1'b0, slot_x} + (X_W+1)'(GLYPH_W);
   assign y_end = {1'b0, slot_y} + (Y_W+1)'(GLYPH_H);

   assign hit = slot_vis && pix_valid
             && (pix_x >= slot_x) && ({1'b0, pix_x} < x_end)
             && (pix_y >= slot_y) && ({1'b0, pix_y} < y_end);

   // Offsets are below 16 on a hit, so a 4-bit modular difference is exact.
   assign col = pix_x[3:0] - slot_x[3:0];
   assign row = pix_y[3:0] - slot_y[3:0];

   assign addr = {1'b0, row, 3'b000} + {3'b000, row, 1'b0} + {4'b0000, col};

endmodule

// File: rtl/sharp_overlay.sv
// Sprite placement for sharp glyphs: double-buffered slot table, per-pixel
// hit scan, ROM address issue and 2-cycle realignment of the ROM pixel.
module sharp_overlay
   import sharp_overlay_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int X_W       = 10,
   parameter  int Y_W       = 10,
   localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [SLOT_W-1:0]       wr_slot,
   input  logic [X_W-1:0]          wr_x,
   input  logic [Y_W-1:0]          wr_y,
   input  logic                    wr_vis,
   input  logic                    frame_start,
   input  logic                    pix_valid,
   input  logic [X_W-1:0]          pix_x,
   input  logic [Y_W-1:0]          pix_y,
   output logic [GLYPH_ADDR_W-1:0] rom_addr,
   input  logic                    rom_pixel,
   output logic                    overlay_on,
   output logic                    overlay_valid
);

   glyph_slot_t shadow_reg  [NUM_SLOTS];
   glyph_slot_t active_reg  [NUM_SLOTS];
   glyph_slot_t shadow_next [NUM_SLOTS];

   logic [NUM_SLOTS-1:0]    hit;
   logic [GLYPH_ADDR_W-1:0] slot_addr [NUM_SLOTS];
   logic                    any_hit;
   logic [GLYPH_ADDR_W-1:0] sel_addr;
   logic                    hit_d1_reg;
   logic                    valid_d1_reg;

   // Out-of-range slot indices match no slot, so such writes are dropped.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         shadow_next[i] = shadow_reg[i];
         if (wr_en && wr_slot == SLOT_W'(i)) begin
            shadow_next[i].x   = COORD_W'(wr_x);
            shadow_next[i].y   = COORD_W'(wr_y);
            shadow_next[i].vis = wr_vis;
         end
      end
   end

   // Commit copies the post-write shadow so a same-cycle write is included.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (reset) begin
            shadow_reg[i] <= '0;
            active_reg[i] <= '0;
         end else begin
            shadow_reg[i] <= shadow_next[i];
            if (frame_start) begin
               active_reg[i] <= shadow_next[i];
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      glyph_hit #(
         .X_W (X_W),
         .Y_W (Y_W)
      ) u_hit (
         .slot_x    (X_W'(active_reg[gi].x)),
         .slot_y    (Y_W'(active_reg[gi].y)),
         .slot_vis  (active_reg[gi].vis),
         .pix_valid (pix_valid),
         .pix_x     (pix_x),
         .pix_y     (pix_y),
         .hit       (hit[gi]),
         .addr      (slot_addr[gi])
      );
   end

   // Walk from the top slot down so the lowest hitting index is kept.
   always_comb begin
      any_hit  = 1'b0;
      sel_addr = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit  = 1'b1;
            sel_addr = slot_addr[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr      <= '0;
         hit_d1_reg    <= 1'b0;
         valid_d1_reg  <= 1'b0;
         overlay_on    <= 1'b0;
         overlay_valid <= 1'b0;
      end else begin
         rom_addr      <= sel_addr;
         hit_d1_reg    <= any_hit;
         valid_d1_reg  <= pix_valid;
         overlay_on    <= rom_pixel & hit_d1_reg;
         overlay_valid <= valid_d1_reg;
      end
   end

endmodule

// File: tb/tb_sharp_overlay.sv
// Self-checking bench for sharp_overlay: a behavioural glyph-table model
// predicts rom_addr (1 cycle) and overlay_on/overlay_valid (2 cycles).
module tb_sharp_overlay;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [1:0] wr_slot;
   logic [9:0] wr_x;
   logic [9:0] wr_y;
   logic       wr_vis;
   logic       frame_start;
   logic       pix_valid;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [7:0] rom_addr;
   logic       rom_pixel;
   logic       overlay_on;
   logic       overlay_valid;

   int errors = 0;
   int checks = 0;

   // Glyph ROM stand-in: data follows the registered address.
   bit rom_mem [256];
   assign rom_pixel = rom_mem[rom_addr];

   // Reference tables
   int m_sx [NS];
   int m_sy [NS];
   bit m_sv [NS];
   int a_sx [NS];
   int a_sy [NS];
   bit a_sv [NS];

   // Pending scan stimulus
   int q_x [$];
   int q_y [$];
   bit q_v [$];

   always #5 clk = ~clk;

   sharp_overlay #(
      .NUM_SLOTS (NS),
      .X_W       (10),
      .Y_W       (10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_slot       (wr_slot),
      .wr_x          (wr_x),
      .wr_y          (wr_y),
      .wr_vis        (wr_vis),
      .frame_start   (frame_start),
      .pix_valid     (pix_valid),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .rom_addr      (rom_addr),
      .rom_pixel     (rom_pixel),
      .overlay_on    (overlay_on),
      .overlay_valid (overlay_valid)
   );

   function automatic void model_pixel(input int px, input int py, input bit v,
                                       output bit h, output int a);
      h = 0;
      a = 0;
      for (int i = 0; i < NS; i++) begin
         if (!h && a_sv[i] && v && px >= a_sx[i] && px < a_sx[i] + 10
             && py >= a_sy[i] && py < a_sy[i] + 16) begin
            h = 1;
            a = (py - a_sy[i]) * 10 + (px - a_sx[i]);
         end
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NS; i++) begin
         m_sx[i] = 0; m_sy[i] = 0; m_sv[i] = 0;
         a_sx[i] = 0; a_sy[i] = 0; a_sv[i] = 0;
      end
   endfunction

   function automatic void model_commit();
      for (int i = 0; i < NS; i++) begin
         a_sx[i] = m_sx[i]; a_sy[i] = m_sy[i]; a_sv[i] = m_sv[i];
      end
   endfunction

   task automatic do_write(input int slot, input int x, input int y, input bit vis,
                           input bit fs);
      @(negedge clk);
      wr_en = 1; wr_slot = 2'(slot); wr_x = 10'(x); wr_y = 10'(y); wr_vis = vis;
      frame_start = fs;
      m_sx[slot] = x; m_sy[slot] = y; m_sv[slot] = vis;
      if (fs) model_commit();
      @(negedge clk);
      wr_en = 0; frame_start = 0;
      $display("write slot=%0d x=%0d y=%0d vis=%0d commit=%0d", slot, x, y, vis, fs);
   endtask

   task automatic do_commit();
      @(negedge clk);
      frame_start = 1;
      model_commit();
      @(negedge clk);
      frame_start = 0;
      $display("commit");
   endtask

   // Streams the queued pixels back to back and compares each pipeline stage.
   task automatic run_scan(input string name);
      int n;
      int ea [512];
      bit eh [512];
      bit ev [512];
      int nerr;
      n = q_x.size();
      nerr = errors;
      for (int c = 0; c < n + 2; c++) begin
         @(negedge clk);
         if (c >= 1 && c - 1 < n) begin
            checks++;
            if (rom_addr !== 8'(ea[c-1])) begin
               errors++;
               $display("FAIL %s rom_addr pix=(%0d,%0d) got=%0d exp=%0d", name,
                        q_x[c-1], q_y[c-1], rom_addr, ea[c-1]);
            end
         end
         if (c >= 2) begin
            checks++;
            if (overlay_on !== (eh[c-2] & rom_mem[ea[c-2]])
                || overlay_valid !== ev[c-2]) begin
               errors++;
               $display("FAIL %s overlay pix=(%0d,%0d) got on=%0b valid=%0b exp on=%0b valid=%0b",
                        name, q_x[c-2], q_y[c-2], overlay_on, overlay_valid,
                        eh[c-2] & rom_mem[ea[c-2]], ev[c-2]);
            end
         end
         if (c < n) begin
            pix_valid = q_v[c]; pix_x = 10'(q_x[c]); pix_y = 10'(q_y[c]);
            ev[c] = q_v[c];
            model_pixel(q_x[c], q_y[c], q_v[c], eh[c], ea[c]);
         end else begin
            pix_valid = 0;
         end
      end
      $display("scan %s pixels=%0d new_errors=%0d", name, n, errors - nerr);
      q_x.delete(); q_y.delete(); q_v.delete();
   endtask

   task automatic push_pix(input int x, input int y, input bit v);
      q_x.push_back(x); q_y.push_back(y); q_v.push_back(v);
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(negedge clk);
      model_clear();
      checks++;
      if (rom_addr !== 8'd0 || overlay_on !== 1'b0 || overlay_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got addr=%0d on=%0b valid=%0b exp 0/0/0",
                  rom_addr, overlay_on, overlay_valid);
      end
      reset = 0;
      for (int x = 0; x < 64; x++) push_pix(x * 16, 0, 1);
      run_scan("reset_line");
   endtask

   task automatic test_single_hit();
      do_write(0, 100, 50, 1, 0);
      do_commit();
      push_pix(103, 54, 1); push_pix(99, 54, 1); push_pix(110, 54, 1);
      push_pix(100, 50, 1); push_pix(109, 65, 1); push_pix(109, 66, 1);
      push_pix(103, 54, 0); push_pix(105, 49, 1);
      run_scan("single_hit");
   endtask

   task automatic test_priority();
      do_write(1, 105, 50, 1, 0);
      do_commit();
      push_pix(106, 50, 1); push_pix(112, 50, 1); push_pix(114, 60, 1);
      push_pix(115, 60, 1); push_pix(104, 60, 1);
      run_scan("priority");
   endtask

   task automatic test_shadow();
      do_write(0, 200, 50, 1, 0);
      push_pix(103, 54, 1); push_pix(203, 54, 1);
      run_scan("shadow_uncommitted");
      // Write and commit in the same cycle; pixel goes in the very next cycle.
      @(negedge clk);
      wr_en = 1; wr_slot = 2'd0; wr_x = 10'd300; wr_y = 10'd50; wr_vis = 1;
      frame_start = 1;
      m_sx[0] = 300; m_sy[0] = 50; m_sv[0] = 1;
      model_commit();
      @(negedge clk);
      wr_en = 0; frame_start = 0;
      pix_valid = 1; pix_x = 10'd303; pix_y = 10'd54;
      @(negedge clk);
      pix_valid = 0;
      checks++;
      if (rom_addr !== 8'd43) begin
         errors++;
         $display("FAIL same_cycle_commit rom_addr got=%0d exp=43", rom_addr);
      end
      $display("same-cycle write+commit pix=(303,54) rom_addr=%0d", rom_addr);
      push_pix(103, 54, 1); push_pix(303, 54, 1);
      run_scan("shadow_committed");
   endtask

   task automatic test_boundary();
      do_write(2, 1020, 1010, 1, 1);
      push_pix(1023, 1013, 1); push_pix(0, 1013, 1); push_pix(1020, 1010, 1);
      push_pix(1019, 1013, 1); push_pix(1023, 1009, 1); push_pix(3, 1013, 1);
      run_scan("boundary");
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      pix_valid = 1; pix_x = 10'd303; pix_y = 10'd54;
      repeat (2) @(negedge clk);
      checks++;
      if (overlay_on !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_overlay got=%0b exp=1", overlay_on);
      end
      reset = 1;
      @(negedge clk);
      checks++;
      if (rom_addr !== 8'd0 || overlay_on !== 1'b0 || overlay_valid !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset got addr=%0d on=%0b valid=%0b exp 0/0/0",
                  rom_addr, overlay_on, overlay_valid);
      end
      $display("midframe reset addr=%0d on=%0b valid=%0b", rom_addr, overlay_on, overlay_valid);
      reset = 0;
      pix_valid = 0;
      model_clear();
      push_pix(303, 54, 1); push_pix(106, 50, 1); push_pix(1023, 1013, 1);
      run_scan("after_reset");
      do_commit();
      push_pix(303, 54, 1); push_pix(0, 0, 1);
      run_scan("after_reset_commit");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < NS; s++) begin
            do_write(s, $urandom_range(0, 60), $urandom_range(0, 60),
                     1'($urandom_range(0, 3) != 0), 0);
         end
         if (r == 2) do_write(1, $urandom_range(0, 60), $urandom_range(0, 60), 1, 1);
         else do_commit();
         for (int i = 0; i < 150; i++) begin
            push_pix($urandom_range(0, 79), $urandom_range(0, 85),
                     1'($urandom_range(0, 7) != 0));
         end
         run_scan($sformatf("random_round%0d", r));
      end
   endtask

   initial begin
      reset = 1; wr_en = 0; wr_slot = 0; wr_x = 0; wr_y = 0; wr_vis = 0;
      frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
      for (int i = 0; i < 256; i++) rom_mem[i] = 1'($urandom_range(0, 1));
      rom_mem[43] = 1;
      model_clear();
      test_reset();
      test_single_hit();
      test_priority();
      test_shadow();
      test_boundary();
      test_reset_midframe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
